even_parity_serial_tx: RTL and testbench
========================================

# even_parity_serial_tx

- Serializer that accepts a parallel word over a valid/ready handshake and shifts it out LSB-first on a single serial line.
- Appends one even-parity bit, so every frame of DATA_W+1 bits carries an even number of ones.
- Transmit-side counterpart of the team's serial even-parity detector; its serial_out drives the detector's serial input.
- frame_out marks the cycles that carry frame bits.

## Interface

Parameters:
- DATA_W, default 8, payload width in bits; legal range 2..32.

Ports:
- clk, input, 1, clock; all logic on posedge.
- reset, input, 1, synchronous, active-high.
- data_in, input, DATA_W, payload word; sampled only on accept.
- valid_in, input, 1, producer has a word on data_in.
- ready_out, input-side handshake, output, 1, block can accept a word this cycle.
- serial_out, output, 1, serial bit stream (data LSB first, then parity).
- frame_out, output, 1, high while serial_out carries a frame bit.
- busy, output, 1, high while a frame is in progress (DATA or PARITY state).

## Operation

Accept rule:
- A word is accepted at a posedge where valid_in && ready_out && !reset.
- valid_in with ready_out low is ignored; the producer holds data.
- There is no buffering beyond the shift register.

State machine: IDLE, DATA, PARITY.
- IDLE:
  - serial_out=0, frame_out=0, busy=0, ready_out=1.
  - On accept: load shift register with data_in, register parity = XOR of data_in bits, clear bit counter, go to DATA.
- DATA:
  - serial_out = shift_reg[0], frame_out=1, busy=1, ready_out=0.
  - Each cycle: shift right, increment counter.
  - After bit DATA_W-1 is driven, go to PARITY.
- PARITY:
  - serial_out = parity register, frame_out=1, busy=1, ready_out=1.
  - On accept: load new word, go to DATA. This gives back-to-back frames with no idle gap.
  - Otherwise go to IDLE.

Counter and arithmetic:
- Counter width is $clog2(DATA_W).
- The counter never wraps mid-frame; the compare is counter == DATA_W-1.

Outputs:
- All outputs except ready_out are registered.
- ready_out is combinational from state and is forced 0 while reset is high.

## Timing

- Reset: on a posedge with reset=1, state←IDLE, serial_out←0, frame_out←0, busy←0, shift register, counter and parity ←0; ready_out=0 during reset, 1 in the first cycle after.
- Latency: accept at edge N means data bit 0 appears on serial_out in cycle N+1 (after edge N).
- Frame cycles: data bit k appears in cycle N+1+k; the parity bit appears in cycle N+1+DATA_W.
- Frame length is exactly DATA_W+1 cycles with frame_out=1.
- Throughput: one word per DATA_W+1 cycles when valid_in is held high.
- Reset mid-frame: the frame is aborted with no parity bit emitted; serial_out=0 and frame_out=0 from the next cycle.
- Simultaneous reset and valid_in: reset wins and the word is not accepted.
- data_in changes while busy: no effect on the frame in flight.

## Configuration

- Macro: EVEN_PARITY_TX_ERR_INJECT_EN.
- Defined:
  - Adds port inject_err, input, 1, sampled on accept together with data_in.
  - When set, the registered parity bit for that frame is inverted, producing an odd-parity frame for exercising the detector's error path.
- Undefined:
  - Port is absent; parity is always correct even parity.

## Test plan

- 0xA5 accepted after reset (DATA_W=8) -> serial_out 1,0,1,0,0,1,0,1 then parity 0 over 9 cycles with frame_out=1; then IDLE with frame_out=0 and ready_out=1.
- 0x07 -> data bits 1,1,1,0,0,0,0,0 then parity 1; 0x00 -> nine zeros with frame_out=1.
- valid_in held high with 0x01 then 0xFF -> 18 consecutive frame_out=1 cycles with parity bits 1 then 0; ready_out=1 only in the two PARITY cycles.
- valid_in pulsed while busy (DATA state) with 0x3C -> ignored; the current frame completes unchanged and no extra frame is sent.
- reset asserted in the 4th data cycle of 0xFF -> next cycle serial_out=0, frame_out=0, busy=0; no parity bit emitted; next accept starts a clean frame.
- With EVEN_PARITY_TX_ERR_INJECT_EN: 0xA5 with inject_err=1 -> parity bit 1 (odd frame); the following 0xA5 with inject_err=0 -> parity 0.

Source files
------------

// File: rtl/even_parity_serial_tx.sv
// even_parity_serial_tx: parallel-to-serial transmitter with even parity.
// Accepts a DATA_W-bit word over valid/ready, shifts it out LSB first on
// serial_out, then appends one parity bit so each DATA_W+1 bit frame holds
// an even number of ones. frame_out and busy flag the frame cycles.
// A word may be accepted in the parity cycle, giving back-to-back frames.
// Optional macro EVEN_PARITY_TX_ERR_INJECT_EN adds inject_err, which inverts
// the parity bit of the accepted frame to produce a deliberately bad frame.
module even_parity_serial_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
`ifdef EVEN_PARITY_TX_ERR_INJECT_EN
  input  logic              inject_err,
`endif
  output logic              ready_out,
  output logic              serial_out,
  output logic              frame_out,
  output logic              busy
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                par_q, par_d;
  logic                serial_d;
  logic                frame_d;
  logic                busy_d;
  logic                accept_c;
  logic                word_par_c;

  // Handshake: ready in IDLE and in the parity cycle, never during reset
  always_comb begin
    ready_out = 1'b0;
    if (!reset && (state_q == IDLE || state_q == PARITY)) begin
      ready_out = 1'b1;
    end
    accept_c = valid_in && ready_out;
  end

  // Parity of the incoming word, optionally inverted for error injection
  always_comb begin
`ifdef EVEN_PARITY_TX_ERR_INJECT_EN
    word_par_c = (^data_in) ^ inject_err;
`else
    word_par_c = ^data_in;
`endif
  end

  // Next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    serial_d = 1'b0;
    frame_d  = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d  = DATA;
          shift_d  = data_in;
          cnt_d    = '0;
          par_d    = word_par_c;
          serial_d = data_in[0];
          frame_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end

      DATA: begin
        frame_d = 1'b1;
        busy_d  = 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Last data bit is on the line; parity follows
          state_d  = PARITY;
          serial_d = par_q;
        end else begin
          shift_d  = shift_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          serial_d = shift_d[0];
        end
      end

      PARITY: begin
        if (accept_c) begin
          // Back-to-back frame: no idle gap after the parity bit
          state_d  = DATA;
          shift_d  = data_in;
          cnt_d    = '0;
          par_d    = word_par_c;
          serial_d = data_in[0];
          frame_d  = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      serial_out <= 1'b0;
      frame_out  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      serial_out <= serial_d;
      frame_out  <= frame_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Testbench for even_parity_serial_tx: directed and random stimulus checked
// cycle by cycle against a frame-level model (a queue of pending line bits).
module tb_even_parity_serial_tx;

  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic              serial_out;
  logic              frame_out;
  logic              busy;
`ifdef EVEN_PARITY_TX_ERR_INJECT_EN
  logic              inject_err = 1'b0;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Model: bits still to appear on the line, and this cycle's expectation
  bit exp_q[$];
  bit exp_serial  = 1'b0;
  bit exp_frame   = 1'b0;
  bit last_accept = 1'b0;

  even_parity_serial_tx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
`ifdef EVEN_PARITY_TX_ERR_INJECT_EN
    .inject_err (inject_err),
`endif
    .ready_out  (ready_out),
    .serial_out (serial_out),
    .frame_out  (frame_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue one full frame: data LSB first, then the bit that makes the count even
  task automatic push_frame(input logic [DATA_W-1:0] w, input logic inj);
    bit par;
    for (int k = 0; k < int'(DATA_W); k++) exp_q.push_back(bit'(w[k]));
    par = (($countones(w) % 2) == 1);
    exp_q.push_back(par ^ bit'(inj));
  endtask

  // One clock cycle: drive, check ready, clock, advance model, check outputs
  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d,
                      input logic inj);
    logic exp_ready;
    @(negedge clk);
    reset    = r;
    valid_in = v;
    data_in  = d;
`ifdef EVEN_PARITY_TX_ERR_INJECT_EN
    inject_err = inj;
`endif
    #1;
    exp_ready = !r && (!exp_frame || exp_q.size() == 0);
    check("ready_out", ready_out, exp_ready);
    last_accept = v && exp_ready;
    @(posedge clk);
    if (r) exp_q.delete();
    else if (last_accept) push_frame(d, inj);
    if (exp_q.size() > 0) begin
      exp_serial = exp_q.pop_front();
      exp_frame  = 1'b1;
    end else begin
      exp_serial = 1'b0;
      exp_frame  = 1'b0;
    end
    #1;
    check("serial_out", serial_out, exp_serial);
    check("frame_out", frame_out, exp_frame);
    check("busy", busy, exp_frame);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DATA_W'($urandom), 1'b0);
  endtask

  // Hold valid with the word until it is accepted (bounded)
  task automatic send(input logic [DATA_W-1:0] w, input logic inj);
    int tries = 0;
    do begin
      step(1'b0, 1'b1, w, inj);
      tries++;
    end while (!last_accept && tries < 40);
    n_checks++;
    assert (last_accept) else begin
      n_fails++;
      $error("FAIL accept_timeout observed=0 expected=1 word=%h", w);
    end
  endtask

  initial begin
    // Reset, then idle
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    idle(2);

    // Single frames: 0xA5, 0x07, 0x00
    send(8'hA5, 1'b0);
    idle(10);
    send(8'h07, 1'b0);
    idle(10);
    send(8'h00, 1'b0);
    idle(10);

    // Back-to-back with valid held high: 0x01 then 0xFF
    send(8'h01, 1'b0);
    send(8'hFF, 1'b0);
    idle(10);

    // valid pulsed mid-frame is ignored
    send(8'h5A, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    idle(10);

    // Reset in the 4th data cycle of 0xFF aborts the frame
    send(8'hFF, 1'b0);
    idle(3);
    step(1'b1, 1'b0, '0, 1'b0);
    idle(2);
    send(8'hA5, 1'b0);
    idle(10);

    // Reset together with valid: word not accepted
    step(1'b1, 1'b1, 8'h55, 1'b0);
    idle(3);

    // data_in changing while busy has no effect
    send(8'hC3, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, DATA_W'($urandom), 1'b0);
    idle(3);

`ifdef EVEN_PARITY_TX_ERR_INJECT_EN
    send(8'hA5, 1'b1);
    send(8'hA5, 1'b0);
    idle(10);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 1)),
           DATA_W'($urandom), 1'b0);
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
